// File: rtl/mod3_share_sched_pkg.sv
// mod3_pkg: shared definitions for the mod-3 sharing scheduler.
//   state_t      : scheduler states (IDLE, SHIFT, DONE)
//   R0/R1/R2     : residue encodings
//   next_residue : one step of the bit-serial mod-3 recurrence
package mod3_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] R0 = 2'd0;
   localparam logic [1:0] R1 = 2'd1;
   localparam logic [1:0] R2 = 2'd2;

   // p = 0: current bit weight is 1 mod 3; p = 1: weight is 2 mod 3.
   function automatic logic [1:0] next_residue(input logic [1:0] r,
                                               input logic       p,
                                               input logic       b);
      logic [1:0] n;
      n = r;
      if (b) begin
         case (r)
            R0:      n = p ? R2 : R1;
            R1:      n = p ? R0 : R2;
            default: n = p ? R1 : R0;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/mod3_share_sched_if.sv
// Requester/result bundle between word producers and the mod-3 scheduler.
//   req_valid / req_data / req_ready : per-requester offer and accept pulse
//   busy                             : scheduler occupied with a job
//   res_valid / res_id / res_rem / res_div3 : tagged result
// master = producer/consumer side, slave = scheduler side.
interface mod3_share_sched_if #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              busy;
   logic              res_valid;
   logic [IDW-1:0]    res_id;
   logic [1:0]        res_rem;
   logic              res_div3;

   modport master (
      output req_valid, req_data,
      input  req_ready, busy, res_valid, res_id, res_rem, res_div3
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, busy, res_valid, res_id, res_rem, res_div3
   );
endinterface

// File: rtl/mod3_residue_core.sv
// Bit-serial mod-3 residue engine, fed LSB first.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart (residue 0, weight parity 0)
//   en       : consume bit_in this cycle
//   bit_in   : next bit of the word
//   rem      : residue of the bits consumed so far
module mod3_residue_core
   import mod3_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [1:0] rem
);

   logic par;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rem <= R0;
         par <= 1'b0;
      end else if (en) begin
         rem <= next_residue(rem, par, bit_in);
         par <= ~par;
      end
   end

endmodule

// File: rtl/mod3_share_sched.sv
// Round-robin scheduler sharing one serial mod-3 engine among NREQ requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mod3_share_sched_if (requests in, tagged results out)
// Flow: IDLE grants and captures a word, SHIFT feeds W bits LSB first,
// DONE presents the result and advances the round-robin pointer.
module mod3_share_sched
   import mod3_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = $clog2(NREQ)
) (
   input logic              clk,
   input logic              rst,
   mod3_share_sched_if.slave bus
);

   localparam int   CW     = (W > 2) ? $clog2(W) : 1;
   // Parity of the last bit's weight; used to finish the residue on the
   // final SHIFT edge so the result is registered into the DONE cycle.
   localparam logic P_LAST = (((W - 1) % 2) == 1);

   state_t         state, state_nx;
   logic [IDW-1:0] rr_ptr, cur_id, grant_idx;
   logic           grant_found, accept, last_bit;
   logic [W-1:0]   shreg;
   logic [CW-1:0]  bitcnt;
   logic [1:0]     core_rem, final_rem;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int unsigned cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(rr_ptr) + k) % NREQ;
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(cand);
         end
      end
   end

   assign last_bit  = (state == SHIFT) && (bitcnt == CW'(W - 1));
   assign final_rem = next_residue(core_rem, P_LAST, shreg[0]);
   assign bus.busy  = accept || (state != IDLE);

   always_comb begin
      state_nx      = state;
      accept        = 1'b0;
      bus.req_ready = '0;
      case (state)
         IDLE: begin
            if (grant_found && !rst) begin
               accept                   = 1'b1;
               bus.req_ready[grant_idx] = 1'b1;
               state_nx                 = SHIFT;
            end
         end
         SHIFT:   if (last_bit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         bus.res_valid <= 1'b0;
         bus.res_id    <= '0;
         bus.res_rem   <= R0;
         bus.res_div3  <= 1'b0;
      end else begin
         state         <= state_nx;
         bus.res_valid <= last_bit;
         if (last_bit) begin
            bus.res_id   <= cur_id;
            bus.res_rem  <= final_rem;
            bus.res_div3 <= (final_rem == R0);
         end
         if (state == DONE)
            rr_ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
      end
   end

   // Datapath: word capture at accept, then shift out LSB first.
   always_ff @(posedge clk) begin
      if (accept) begin
         shreg  <= bus.req_data[int'(grant_idx)*W +: W];
         cur_id <= grant_idx;
         bitcnt <= '0;
      end else if (state == SHIFT) begin
         shreg  <= shreg >> 1;
         bitcnt <= bitcnt + 1'b1;
      end
   end

   mod3_residue_core u_core (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (state == SHIFT),
      .bit_in (shreg[0]),
      .rem    (core_rem)
   );

endmodule

// File: tb/tb_mod3_share_sched.sv
// Directed self-checking bench for mod3_share_sched (NREQ=4, W=8).
module tb_mod3_share_sched;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   mod3_share_sched_if #(.NREQ(NREQ), .W(W)) bus ();

   mod3_share_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int id, input logic [7:0] w);
      bus.req_data[id*W +: W] = w;
   endtask

   // One isolated job: grant, W shift cycles, result at accept+W+1.
   task automatic run_one(input int id, input logic [7:0] w, input logic [1:0] exp_rem);
      int n;
      set_word(id, w);
      bus.req_valid = NREQ'(1 << id);
      #1;
      n = 0;
      while (bus.req_ready == '0 && n < 40) begin
         tick();
         n++;
      end
      chk("ready", 32'(bus.req_ready), 32'(1 << id));
      chk("busy_accept", 32'(bus.busy), 32'd1);
      tick();
      bus.req_valid = '0;
      repeat (W - 1) tick();
      chk("no_early_valid", 32'(bus.res_valid), 32'd0);
      tick();
      chk("res_valid", 32'(bus.res_valid), 32'd1);
      chk("res_id", 32'(bus.res_id), 32'(id));
      chk("res_rem", 32'(bus.res_rem), 32'(exp_rem));
      chk("res_div3", 32'(bus.res_div3), (exp_rem == 2'd0) ? 32'd1 : 32'd0);
      tick();
      chk("valid_pulse", 32'(bus.res_valid), 32'd0);
   endtask

   initial begin
      int k, c, last_c, cnt;
      int exp_id[5];
      int exp_rem[5];
      exp_id  = '{0, 1, 2, 3, 0};
      exp_rem = '{0, 1, 2, 0, 0};

      // Reset with every requester valid: no accept may happen.
      bus.req_valid = '1;
      bus.req_data  = '0;
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_id", 32'(bus.res_id), 32'd0);
      chk("rst_rem", 32'(bus.res_rem), 32'd0);
      chk("rst_div3", 32'(bus.res_div3), 32'd0);
      tick();
      rst = 1'b0;
      bus.req_valid = '0;
      tick();
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Basic words.
      run_one(0, 8'h07, 2'd1);
      run_one(0, 8'hFF, 2'd0);
      run_one(1, 8'h00, 2'd0);
      run_one(2, 8'h05, 2'd2);

      // Word changes during SHIFT must not affect the result.
      set_word(2, 8'h07);
      bus.req_valid = 4'b0100;
      #1;
      chk("cap_ready", 32'(bus.req_ready), 32'b0100);
      tick();
      bus.req_valid = '0;
      set_word(2, 8'h06);
      repeat (W) tick();
      chk("cap_valid", 32'(bus.res_valid), 32'd1);
      chk("cap_id", 32'(bus.res_id), 32'd2);
      chk("cap_rem", 32'(bus.res_rem), 32'd1);
      tick();

      // Round-robin with all four held valid, pointer restarted by reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_word(0, 8'd3);
      set_word(1, 8'd4);
      set_word(2, 8'd5);
      set_word(3, 8'd6);
      bus.req_valid = '1;
      #1;
      k = 0; cnt = 0; c = 0; last_c = 0;
      while (k < 5 && c < 80) begin
         if (bus.req_ready != '0 && cnt < 5) begin
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << exp_id[cnt]));
            cnt++;
         end
         if (bus.res_valid) begin
            chk("rr_id", 32'(bus.res_id), 32'(exp_id[k]));
            chk("rr_rem", 32'(bus.res_rem), 32'(exp_rem[k]));
            if (k > 0) chk("rr_spacing", 32'(c - last_c), 32'd10);
            last_c = c;
            k++;
            if (k == 5) bus.req_valid = '0;
         end
         if (k < 5) begin
            tick();
            c++;
         end
      end
      chk("rr_count", 32'(k), 32'd5);
      tick();

      // Reset during the 4th SHIFT cycle aborts the job and the pointer.
      set_word(2, 8'h07);
      bus.req_valid = 4'b0100;
      #1;
      chk("abort_grant", 32'(bus.req_ready), 32'b0100);
      tick();
      bus.req_valid = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_valid", 32'(bus.res_valid), 32'd0);
      rst = 1'b0;
      bus.req_valid = '1;
      #1;
      chk("abort_ptr0", 32'(bus.req_ready), 32'b0001);
      tick();
      bus.req_valid = '0;
      cnt = 0;
      for (int i = 0; i < W - 1; i++) begin
         if (bus.res_valid) cnt++;
         tick();
      end
      if (bus.res_valid) cnt++;
      chk("abort_no_result", 32'(cnt), 32'd0);
      tick();
      chk("after_valid", 32'(bus.res_valid), 32'd1);
      chk("after_id", 32'(bus.res_id), 32'd0);
      chk("after_rem", 32'(bus.res_rem), 32'd0);
      tick();

      // Exhaustive sweep through requester 3.
      for (int w = 0; w < 256; w++)
         run_one(3, 8'(w), 2'(w % 3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
